fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning number of fetched-instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; one clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port inst_address, output, 32, instruction fetch address to memory.
REQ-006 SHALL have port inst_read_enable, output, 1, fetch request to memory.
REQ-007 SHALL have port inst_read_data, input, 32, memory read data, combinationally valid in the same cycle as the request.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instr (output, 32), out_pc (output, 32), the decode-side valid/ready handshake.
REQ-009 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32), the control-flow redirect request.
REQ-010 SHALL have port halted, output, 1, high while the fetch FSM is in HALT.

Function
REQ-011 SHALL hold pc register; inst_address = pc with bits [1:0] always 0.
REQ-012 SHALL assert inst_read_enable only when state = RUN, FIFO not full (or dequeued this cycle), and redirect_valid = 0.
REQ-013 SHALL, in each enabled cycle, enqueue {pc, inst_read_data} and advance pc by 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
REQ-014 SHALL present the FIFO head on out_instr/out_pc with out_valid = FIFO not empty; out_instr/out_pc = 0 when empty.
REQ-015 SHALL dequeue the head on out_valid && out_ready; enqueue and dequeue in the same cycle keep count unchanged.
REQ-016 SHALL have minimum latency 1 cycle: word requested in cycle N appears on out_* in cycle N+1.
REQ-017 SHALL be a two-state FSM, RUN and HALT; RUN -> HALT on enqueue of a halting word (see Configuration); HALT -> RUN only on redirect_valid.
REQ-018 SHALL, on redirect_valid, flush all FIFO entries, load pc = {redirect_pc[31:2], 2'b00}, enter RUN, and issue no fetch that cycle.
REQ-019 SHALL give redirect priority over a simultaneous dequeue; the dropped head is not counted as consumed.
REQ-020 SHALL in HALT keep inst_read_enable = 0 and continue draining buffered entries to decode.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready.

Reset
REQ-022 SHALL, while reset = 1, set pc = RESET_VECTOR, FIFO empty, state = RUN.
REQ-023 SHALL drive out_valid = 0, halted = 0, inst_read_enable = 0 during reset; first fetch in the first cycle after reset deasserts.
REQ-024 SHALL discard buffered entries and any in-progress fetch when reset asserts mid-operation.

Configuration
REQ-025 SHALL use macro FETCH_EBREAK_HALT_EN.
REQ-026 SHALL, with FETCH_EBREAK_HALT_EN defined, treat an enqueued word equal to 32'h0010_0073 (EBREAK) as halting: it is buffered and delivered, then FSM enters HALT.
REQ-027 SHALL, without FETCH_EBREAK_HALT_EN, never leave RUN; EBREAK is fetched as an ordinary word and halted is tied to 0.

Verification
REQ-028 SHALL cover: reset release, memory words 0x0000_0000 at 0x0, 0x0010_0073 at 0x4, out_ready=1 -> out_pc 0x0 then 0x4 on consecutive cycles; with macro halted=1 after EBREAK enqueue, no request to 0x8.
REQ-029 SHALL cover: out_ready=0 for 5 cycles -> exactly FIFO_DEPTH (2) fetches (0x0, 0x4), then inst_read_enable=0, out_pc held at 0x0.
REQ-030 SHALL cover: redirect_valid with redirect_pc=0x0000_0103 while FIFO full -> FIFO empty next cycle, next inst_address=0x0000_0100, no stale entry delivered.
REQ-031 SHALL cover: redirect_valid and out_ready in same cycle -> head dropped, next out_pc = redirect target.
REQ-032 SHALL cover: pc=0xFFFF_FFFC -> following fetch address 0x0000_0000.
REQ-033 SHALL cover: reset asserted with two buffered entries -> out_valid=0 next cycle, first post-reset inst_address = RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc sequencer, fetched-word FIFO and RUN/HALT FSM.
// Optional FETCH_EBREAK_HALT_EN makes an enqueued EBREAK halt fetching.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_address,
  output logic        inst_read_enable,
  input  logic [31:0] inst_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     pc_q    [FIFO_DEPTH];
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            deq;
  logic            fetch;
  logic            is_halt;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign deq   = !reset && !empty && out_ready && !redirect_valid;
  assign fetch = !reset && (state == RUN) && !redirect_valid
               && (!full || deq);

  assign inst_address     = {pc[31:2], 2'b00};
  assign inst_read_enable = fetch;

`ifdef FETCH_EBREAK_HALT_EN
  assign is_halt = fetch && (inst_read_data == EBREAK);
  assign halted  = !reset && (state == HALT);
`else
  assign is_halt = 1'b0;
  assign halted  = 1'b0;
`endif

  // Outputs are zeroed whenever nothing is presentable, including reset.
  assign out_valid = !reset && !empty;
  assign out_instr = out_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_VECTOR;
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        pc_q[wr_ptr]    <= inst_address;
        instr_q[wr_ptr] <= inst_read_data;
        wr_ptr          <= wr_ptr + 1'b1;
        pc              <= inst_address + 32'd4;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(fetch) - CW'(deq);
      if (is_halt)
        state <= HALT;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
// Directed sequences exercise halt, stall, redirect, wrap and mid-run reset.
module tb_fetch_unit;

  localparam int          D  = 2;
  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef FETCH_EBREAK_HALT_EN
  localparam bit EB = 1'b1;
`else
  localparam bit EB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_address;
  logic        inst_read_enable;
  logic [31:0] inst_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .inst_address(inst_address),
    .inst_read_enable(inst_read_enable),
    .inst_read_data(inst_read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
  );

  // Memory image: hashed words with up to two overridden locations.
  logic        ov_en = 1'b0;
  logic [31:0] ov_a0, ov_d0, ov_a1, ov_d1;

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (ov_en && a == ov_a0) w = ov_d0;
    if (ov_en && a == ov_a1) w = ov_d1;
    return w;
  endfunction

  always_comb begin
    inst_read_data = (inst_address * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (ov_en && inst_address == ov_a0) inst_read_data = ov_d0;
    if (ov_en && inst_address == ov_a1) inst_read_data = ov_d1;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          last_re;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv,
                      input logic [31:0] rpc, input bit rdy);
    bit          e_re;
    bit          e_v;
    bit          dq;
    logic [31:0] w;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    e_v  = !r && q.size() > 0;
    dq   = e_v && rdy && !rv;
    e_re = !r && !rv && !m_halt && (q.size() < D || dq);
    last_re = inst_read_enable;
    chk("addr",   inst_address,     m_pc);
    chk("re",     32'(inst_read_enable), 32'(e_re));
    chk("valid",  32'(out_valid),   32'(e_v));
    chk("instr",  out_instr,        e_v ? q[0].instr : 32'h0);
    chk("pc",     out_pc,           e_v ? q[0].pc    : 32'h0);
    chk("halted", 32'(halted),      32'(!r && m_halt));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pc   = RV;
      m_halt = 1'b0;
    end else if (rv) begin
      q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      if (dq) void'(q.pop_front());
      if (e_re) begin
        w = memw(m_pc);
        q.push_back('{pc: m_pc, instr: w});
        if (EB && w == 32'h0010_0073) m_halt = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int nf;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();
    m_pc   = RV;
    m_halt = 1'b0;

    // Word 0 at 0x0, EBREAK at 0x4, decode always ready.
    ov_a0 = 32'h0; ov_d0 = 32'h0;
    ov_a1 = 32'h4; ov_d1 = 32'h0010_0073;
    ov_en = 1'b1;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    ov_en = 1'b0;

    // Decode stalled: only D fetches then the head holds.
    nf = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      nf += int'(last_re);
    end
    chk("stall_fetches", 32'(nf), 32'(D));

    // Redirect while full, then run.
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect coincident with a dequeue.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with two buffered entries.
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic, with EBREAK planted at a few addresses.
    ov_a0 = 32'h0000_0010; ov_d0 = 32'h0010_0073;
    ov_a1 = 32'h0000_0024; ov_d1 = 32'h0010_0073;
    ov_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit          r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       rpc = 32'($urandom_range(0, 63));
        default: rpc = $urandom;
      endcase
      step(r, rv, rpc, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
